fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction held in IF/ID when it carries no valid instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  decode stage not accepting; IF/ID register holds.
REQ-006 redirect_valid  input  1  branch/jump taken; flushes and retargets fetch.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_addr  output  32  request address, word aligned.
REQ-010 imem_req_ready  input  1  memory accepts request this cycle.
REQ-011 imem_rsp_valid  input  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  input  32  fetched instruction.
REQ-013 id_valid  output  1  IF/ID register holds a real instruction.
REQ-014 id_pc / id_instr  output  32 / 32  IF/ID registered PC and instruction.
REQ-015 id_opcode / id_funct3 / id_funct7  output  7 / 3 / 7  id_instr[6:0] / [14:12] / [31:25], combinational from id_instr, feeding the control unit.
REQ-016 id_rd / id_rs1 / id_rs2  output  5 / 5 / 5  id_instr[11:7] / [19:15] / [24:20].

Function
REQ-017 States: S_REQ, S_WAIT, S_HOLD; at most one outstanding memory request.
REQ-018 S_REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> S_WAIT, latch req_pc=pc.
REQ-019 imem_req_valid SHALL be 0 in S_WAIT and S_HOLD.
REQ-020 S_WAIT, imem_rsp_valid, discard=0, stall=0: load IF/ID {valid=1, req_pc, rsp_data}, pc<=req_pc+4 (mod 2^32), -> S_REQ.
REQ-021 S_WAIT, imem_rsp_valid, discard=0, stall=1: capture rsp_data into skid buffer, -> S_HOLD; IF/ID unchanged.
REQ-022 S_HOLD, stall=0: load IF/ID from skid buffer with req_pc, pc<=req_pc+4, -> S_REQ.
REQ-023 S_WAIT, imem_rsp_valid, discard=1: drop response, clear discard, -> S_REQ; IF/ID unchanged.
REQ-024 stall=1 without redirect: IF/ID holds all fields; fetch may proceed until S_HOLD.
REQ-025 No new instruction is loaded into IF/ID while stall=1; if stall=0 and no load occurs, id_valid<=0 and id_instr<=NOP_INSTR (bubble).
REQ-026 redirect_valid (priority over stall and responses, any state): pc<={redirect_pc[31:2],2'b00}; id_valid<=0, id_instr<=NOP_INSTR; skid buffer discarded.
REQ-027 Redirect in S_REQ without request acceptance, or in S_HOLD -> S_REQ; request issues next cycle at the new pc.
REQ-028 Redirect in S_WAIT with no imem_rsp_valid, or in S_REQ with imem_req_ready=1 the same cycle -> S_WAIT with discard=1.
REQ-029 Redirect in S_WAIT coincident with imem_rsp_valid: response dropped, -> S_REQ, discard=0.
REQ-030 Fetch-to-IF/ID latency with zero-wait memory (ready=1, rsp next cycle): 2 cycles; steady throughput one instruction per 2 cycles.

Reset
REQ-031 rst=1 at a clock edge: state=S_REQ, pc=RESET_PC, discard=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR; overrides redirect and stall.
REQ-032 First cycle after reset release: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-033 Responses arriving after reset to pre-reset requests are outside this block's contract; memory SHALL be reset together with it.

Verification
REQ-034 Reset, ready=1, rsp 1 cycle later with 32'h0000_0033 -> id_valid=1, id_pc=0, id_opcode=7'b0110011, next request addr=4.
REQ-035 Stall=1 while rsp 32'h0020_8093 arrives at pc 8 -> S_HOLD, IF/ID unchanged, no request; stall drops -> IF/ID {8, 32'h0020_8093}, id_rd=1, id_funct3=0, next addr 12.
REQ-036 Redirect to 32'h0000_0103 while S_WAIT -> id_valid=0, id_instr=NOP; late response dropped; next request addr 32'h0000_0100.
REQ-037 Redirect and rsp_valid same cycle -> response not loaded, next cycle request at redirect address.
REQ-038 Redirect with stall=1 -> IF/ID flushed to NOP despite stall.
REQ-039 pc=32'hFFFF_FFFC fetch completes -> next request addr 32'h0000_0000; rst mid-S_WAIT -> outputs at REQ-031 values next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// a one-entry skid buffer for responses that arrive while decode is stalled,
// and the IF/ID pipeline register with its field decode.
//
// state  | meaning
// S_REQ  | request at pc is presented to instruction memory
// S_WAIT | request accepted, waiting for its response (dropped if discard set)
// S_HOLD | response parked in skid buffer until decode stops stalling
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [6:0]  id_opcode_o,
  output logic [2:0]  id_funct3_o,
  output logic [6:0]  id_funct7_o,
  output logic [4:0]  id_rd_o,
  output logic [4:0]  id_rs1_o,
  output logic [4:0]  id_rs2_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] skid_q, skid_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        load;
  logic [31:0] load_data;

  // State and pipeline registers; reset wins over redirect and stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      discard_q  <= 1'b0;
      skid_q     <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      skid_q     <= skid_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  // Next-state, fetch pc and IF/ID update; redirect takes priority over all.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    skid_d     = skid_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    load       = 1'b0;
    load_data  = skid_q;

    if (redirect_valid_i) begin
      pc_d       = redirect_pc_i & 32'hFFFF_FFFC;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      discard_d  = 1'b0;
      case (state_q)
        S_REQ: begin
          // A request accepted this very cycle is stale; its response must be dropped.
          if (imem_req_ready_i) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            state_d = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready_i) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (!stall_i) begin
              load      = 1'b1;
              load_data = imem_rsp_data_i;
              state_d   = S_REQ;
            end else begin
              skid_d  = imem_rsp_data_i;
              state_d = S_HOLD;
            end
          end
        end
        default: begin
          if (!stall_i) begin
            load    = 1'b1;
            state_d = S_REQ;
          end
        end
      endcase

      if (load) begin
        pc_d       = req_pc_q + 32'd4;
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_instr_d = load_data;
      end else if (!stall_i) begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  // Request interface and IF/ID field decode for the control unit.
  always_comb begin
    imem_req_valid_o = (state_q == S_REQ);
    imem_req_addr_o  = pc_q;
    id_valid_o       = id_valid_q;
    id_pc_o          = id_pc_q;
    id_instr_o       = id_instr_q;
    id_opcode_o      = id_instr_q[6:0];
    id_funct3_o      = id_instr_q[14:12];
    id_funct7_o      = id_instr_q[31:25];
    id_rd_o          = id_instr_q[11:7];
    id_rs1_o         = id_instr_q[19:15];
    id_rs2_o         = id_instr_q[24:20];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed cycle table for the documented corner
// cases, then random traffic against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_pc, id_instr;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rd, id_rs1, id_rs2;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_req_valid_o(imem_req_valid), .imem_req_addr_o(imem_req_addr),
    .imem_req_ready_i(imem_req_ready), .imem_rsp_valid_i(imem_rsp_valid),
    .imem_rsp_data_i(imem_rsp_data),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
    .id_opcode_o(id_opcode), .id_funct3_o(id_funct3), .id_funct7_o(id_funct7),
    .id_rd_o(id_rd), .id_rs1_o(id_rs1), .id_rs2_o(id_rs2)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ready, rsp;
    logic [31:0] rdata;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic rv, input logic [31:0] dat,
                              input logic erv, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rp; v.ready = rdy; v.rsp = rv; v.rdata = dat;
    v.e_reqv = erv; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic ev, input logic [31:0] epc, input logic [31:0] ei);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(ev));
    chk({tag, ".id_pc"}, id_pc, epc);
    chk({tag, ".id_instr"}, id_instr, ei);
    chk({tag, ".id_opcode"}, 32'(id_opcode), 32'(ei[6:0]));
    chk({tag, ".id_funct3"}, 32'(id_funct3), 32'(ei[14:12]));
    chk({tag, ".id_funct7"}, 32'(id_funct7), 32'(ei[31:25]));
    chk({tag, ".id_rd"}, 32'(id_rd), 32'(ei[11:7]));
    chk({tag, ".id_rs1"}, 32'(id_rs1), 32'(ei[19:15]));
    chk({tag, ".id_rs2"}, 32'(id_rs2), 32'(ei[24:20]));
  endtask

  // Reference model state for the random phase.
  logic        pending, held, drop, accepted, rsp_now, loaded;
  logic [31:0] paddr, acc_addr, exp_pc, e_pc, e_instr;
  logic        e_valid;
  int          pdelay, loads;
  logic        r_rst, r_stall, r_redir, r_ready;
  logic [31:0] r_rpc;

  initial begin
    //             rst stall redir rpc            rdy rsp data           reqv addr           valid pc             instr
    tbl[0]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          NOP);
    tbl[1]  = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,          NOP);
    tbl[2]  = mk(0, 0, 0, 32'h0,          0, 1, 32'h0000_0033, 1, 32'h0000_0004, 1, 32'h0,          32'h0000_0033);
    tbl[3]  = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h0,          NOP);
    tbl[4]  = mk(0, 0, 0, 32'h0,          0, 1, 32'h0010_0093, 1, 32'h0000_0008, 1, 32'h4,          32'h0010_0093);
    tbl[5]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         1, 32'h4,          32'h0010_0093);
    tbl[6]  = mk(0, 1, 0, 32'h0,          0, 1, 32'h0020_8093, 0, 32'h0,         1, 32'h4,          32'h0010_0093);
    tbl[7]  = mk(0, 1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         1, 32'h4,          32'h0010_0093);
    tbl[8]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h8,          32'h0020_8093);
    tbl[9]  = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h8,          NOP);
    tbl[10] = mk(0, 0, 1, 32'h0000_0103, 0, 0, 32'h0,          0, 32'h0,         0, 32'h8,          NOP);
    tbl[11] = mk(0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF, 1, 32'h0000_0100, 0, 32'h8,          NOP);
    tbl[12] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h8,          NOP);
    tbl[13] = mk(0, 0, 1, 32'h0000_0200, 0, 1, 32'h1234_5678, 1, 32'h0000_0200, 0, 32'h8,          NOP);
    tbl[14] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h8,          NOP);
    tbl[15] = mk(0, 0, 0, 32'h0,          0, 1, 32'h0000_0033, 1, 32'h0000_0204, 1, 32'h200,        32'h0000_0033);
    tbl[16] = mk(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h200,        NOP);
    tbl[17] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'h200,        NOP);
    tbl[18] = mk(0, 0, 0, 32'h0,          0, 1, 32'h0050_0113, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0050_0113);
    tbl[19] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         0, 32'hFFFF_FFFC, NOP);
    tbl[20] = mk(1, 1, 1, 32'h0000_0400, 1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          NOP);
    tbl[21] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          NOP);

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall; redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc; imem_req_ready = tbl[i].ready;
      imem_rsp_valid = tbl[i].rsp; imem_rsp_data = tbl[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("row%0d.req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_reqv));
      if (tbl[i].e_reqv) chk($sformatf("row%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
      check_id($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr);
    end

    pending = 0; held = 0; drop = 0; pdelay = 0; paddr = 0; loads = 0;
    exp_pc = RST_PC; e_valid = 0; e_pc = 0; e_instr = NOP;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_rst   = (cyc == 0) || ($urandom_range(0, 199) == 0);
      r_stall = $urandom_range(0, 9) < 3;
      r_redir = $urandom_range(0, 19) == 0;
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      r_ready = $urandom_range(0, 9) < 6;
      rsp_now = pending && (pdelay == 0);
      rst = r_rst; stall = r_stall; redirect_valid = r_redir; redirect_pc = r_rpc;
      imem_req_ready = r_ready; imem_rsp_valid = rsp_now;
      imem_rsp_data = rsp_now ? mem_word(paddr) : $urandom;
      #1;
      if (cyc > 0) begin
        chk("rand.req_valid", 32'(imem_req_valid), 32'(!pending && !held));
        if (!pending && !held) chk("rand.req_addr", imem_req_addr, exp_pc);
      end
      accepted = imem_req_valid && r_ready;
      acc_addr = imem_req_addr;
      @(posedge clk); #1;

      if (r_rst) begin
        pending = 0; held = 0; drop = 0;
        exp_pc = RST_PC; e_valid = 0; e_pc = 0; e_instr = NOP;
      end else begin
        loaded = 0;
        if (rsp_now) pending = 0;
        else if (pending) pdelay--;
        if (r_redir) begin
          drop = pending;
          held = 0;
          exp_pc = r_rpc & 32'hFFFF_FFFC;
          e_valid = 0; e_instr = NOP;
        end else begin
          if (rsp_now) begin
            if (drop) drop = 0;
            else if (!r_stall) loaded = 1;
            else held = 1;
          end else if (held && !r_stall) begin
            loaded = 1; held = 0;
          end
          if (loaded) begin
            e_valid = 1; e_pc = exp_pc; e_instr = mem_word(exp_pc);
            exp_pc = exp_pc + 32'd4;
            loads++;
          end else if (!r_stall) begin
            e_valid = 0; e_instr = NOP;
          end
        end
        if (accepted) begin
          pending = 1; paddr = acc_addr; pdelay = $urandom_range(0, 3);
          if (r_redir) drop = 1;
        end
      end
      check_id("rand", e_valid, e_pc, e_instr);
    end
    chk("rand.loads_seen", 32'(loads > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
